// File: rtl/jam_assign_n.sv
// jam_assign_n: exhaustive N-job / N-worker assignment search over all N! permutations.
// Define JAM_BEST_PERM_EN to keep the first minimal assignment on BestJ (otherwise BestJ is 0).
module jam_assign_n #(
    parameter int N   = 8,
    parameter int CW  = 7,
    parameter int MCW = 16,
    localparam int IW = $clog2(N),
    localparam int SW = CW + IW
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    output logic            busy,
    output logic [IW-1:0]   W,
    output logic [IW-1:0]   J,
    input  logic [CW-1:0]   Cost,
    output logic [SW-1:0]   MinCost,
    output logic [MCW-1:0]  MatchCount,
    output logic [N*IW-1:0] BestJ,
    output logic            Valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_CMP,
        S_PIVOT,
        S_SWAP,
        S_DONE
    } state_t;

    localparam logic [IW-1:0]  LAST_IDX    = IW'(N - 1);
    localparam logic [IW-1:0]  PIVOT_START = IW'(N - 2);
    localparam logic [MCW-1:0] COUNT_MAX   = '1;

    state_t               state_q, state_d;
    logic [N-1:0][IW-1:0] perm_q, perm_d;
    logic [SW-1:0]        sum_q, sum_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        k_q, k_d;
    logic                 first_q, first_d;
    logic [SW-1:0]        min_cost_q, min_cost_d;
    logic [MCW-1:0]       match_count_q, match_count_d;
    logic                 valid_q, valid_d;

    logic [N-1:0][IW-1:0] perm_init;
    logic [N-1:0][IW-1:0] perm_swapped;
    logic [N-1:0][IW-1:0] perm_next;
    logic [IW-1:0]        s_idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_init
        assign perm_init[gi] = IW'(gi);
    end

`ifdef JAM_BEST_PERM_EN
    logic [N-1:0][IW-1:0] best_j_q, best_j_d;
`endif

    // Successor permutation: the suffix after pivot k is descending, so the
    // last element above perm[k] is the smallest larger one.
    always_comb begin
        s_idx = k_q;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) > k_q && perm_q[IW'(i)] > perm_q[k_q]) begin
                s_idx = IW'(i);
            end
        end
        perm_swapped        = perm_q;
        perm_swapped[k_q]   = perm_q[s_idx];
        perm_swapped[s_idx] = perm_q[k_q];
        perm_next           = perm_swapped;
        for (int i = 0; i < N; i++) begin
            if (IW'(i) > k_q) begin
                perm_next[IW'(i)] = perm_swapped[IW'(N + int'(k_q) - i)];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        perm_d        = perm_q;
        sum_d         = sum_q;
        idx_d         = idx_q;
        k_d           = k_q;
        first_d       = first_q;
        min_cost_d    = min_cost_q;
        match_count_d = match_count_q;
        valid_d       = 1'b0;
`ifdef JAM_BEST_PERM_EN
        best_j_d      = best_j_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    perm_d  = perm_init;
                    sum_d   = '0;
                    idx_d   = '0;
                    first_d = 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                sum_d = sum_q + SW'(Cost);
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (first_q || sum_q < min_cost_q) begin
                    min_cost_d    = sum_q;
                    match_count_d = MCW'(1);
                    first_d       = 1'b0;
`ifdef JAM_BEST_PERM_EN
                    best_j_d      = perm_q;
`endif
                end else if (sum_q == min_cost_q && match_count_q != COUNT_MAX) begin
                    match_count_d = match_count_q + MCW'(1);
                end
                k_d     = PIVOT_START;
                state_d = S_PIVOT;
            end
            S_PIVOT: begin
                if (perm_q[k_q] < perm_q[k_q + IW'(1)]) begin
                    state_d = S_SWAP;
                end else if (k_q == '0) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    k_d = k_q - IW'(1);
                end
            end
            S_SWAP: begin
                perm_d  = perm_next;
                sum_d   = '0;
                idx_d   = '0;
                state_d = S_EVAL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            perm_q        <= perm_init;
            sum_q         <= '0;
            idx_q         <= '0;
            k_q           <= '0;
            first_q       <= 1'b0;
            min_cost_q    <= '0;
            match_count_q <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            perm_q        <= perm_d;
            sum_q         <= sum_d;
            idx_q         <= idx_d;
            k_q           <= k_d;
            first_q       <= first_d;
            min_cost_q    <= min_cost_d;
            match_count_q <= match_count_d;
            valid_q       <= valid_d;
        end
    end

`ifdef JAM_BEST_PERM_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            best_j_q <= '0;
        end else begin
            best_j_q <= best_j_d;
        end
    end
    assign BestJ = best_j_q;
`else
    assign BestJ = '0;
`endif

    assign busy       = (state_q == S_EVAL) || (state_q == S_CMP) ||
                        (state_q == S_PIVOT) || (state_q == S_SWAP);
    assign W          = (state_q == S_EVAL) ? idx_q : '0;
    assign J          = (state_q == S_EVAL) ? perm_q[idx_q] : '0;
    assign MinCost    = min_cost_q;
    assign MatchCount = match_count_q;
    assign Valid      = valid_q;

endmodule

// File: tb/tb_jam_assign_n.sv
// Directed self-checking bench for jam_assign_n: N=4 tables, N=3 latency, N=5 count saturation.
module tb_jam_assign_n;

`ifdef JAM_BEST_PERM_EN
    localparam bit BEST_EN = 1'b1;
`else
    localparam bit BEST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start4, start3, start5;
    int   mode4;

    // N=4 instance
    logic        busy4, valid4;
    logic [1:0]  w4, j4;
    logic [6:0]  cost4;
    logic [8:0]  min4;
    logic [15:0] cnt4;
    logic [7:0]  best4;

    // N=3 instance
    logic        busy3, valid3;
    logic [1:0]  w3, j3;
    logic [6:0]  cost3;
    logic [8:0]  min3;
    logic [15:0] cnt3;
    logic [5:0]  best3;

    // N=5 instances, narrow (saturating) and wide count
    logic        busy5s, valid5s, busy5f, valid5f;
    logic [2:0]  w5s, j5s, w5f, j5f;
    logic [9:0]  min5s, min5f;
    logic [5:0]  cnt5s;
    logic [15:0] cnt5f;
    logic [14:0] best5s, best5f;

    always_comb begin
        case (mode4)
            0:       cost4 = (int'(j4) == 3 - int'(w4)) ? 7'd1 : 7'd50;
            1:       cost4 = 7'd5;
            default: cost4 = (j4 == (w4 ^ 2'd1)) ? 7'd3 : 7'd9;
        endcase
    end
    assign cost3 = (w3 == j3) ? 7'd0 : 7'd9;

    jam_assign_n #(.N(4), .CW(7), .MCW(16)) u4 (
        .CLK(clk), .RST_N(rst_n), .start(start4), .busy(busy4), .W(w4), .J(j4),
        .Cost(cost4), .MinCost(min4), .MatchCount(cnt4), .BestJ(best4), .Valid(valid4)
    );
    jam_assign_n #(.N(3), .CW(7), .MCW(16)) u3 (
        .CLK(clk), .RST_N(rst_n), .start(start3), .busy(busy3), .W(w3), .J(j3),
        .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .BestJ(best3), .Valid(valid3)
    );
    jam_assign_n #(.N(5), .CW(7), .MCW(6)) u5s (
        .CLK(clk), .RST_N(rst_n), .start(start5), .busy(busy5s), .W(w5s), .J(j5s),
        .Cost(7'd0), .MinCost(min5s), .MatchCount(cnt5s), .BestJ(best5s), .Valid(valid5s)
    );
    jam_assign_n #(.N(5), .CW(7), .MCW(16)) u5f (
        .CLK(clk), .RST_N(rst_n), .start(start5), .busy(busy5f), .W(w5f), .J(j5f),
        .Cost(7'd0), .MinCost(min5f), .MatchCount(cnt5f), .BestJ(best5f), .Valid(valid5f)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bexp(input logic [31:0] v);
        return BEST_EN ? v : 32'd0;
    endfunction

    // Waits for Valid of the selected instance; cyc = edges after the start edge.
    task automatic wait_valid(input int id, input int limit, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            case (id)
                0:       seen = valid4;
                1:       seen = valid3;
                default: seen = valid5s;
            endcase
        end
        n_cmp++;
        assert (seen) else begin
            n_fail++;
            $error("FAIL timeout_%0d observed=no_valid expected=valid_within_%0d", id, limit);
        end
    endtask

    task automatic pulse_start4();
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  any_activity;

        rst_n  = 1'b0;
        start4 = 1'b0;
        start3 = 1'b0;
        start5 = 1'b0;
        mode4  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy4},  32'd0);
        check("rst_valid", {31'd0, valid4}, 32'd0);
        check("rst_w",     32'(w4),    32'd0);
        check("rst_j",     32'(j4),    32'd0);
        check("rst_min",   32'(min4),  32'd0);
        check("rst_cnt",   32'(cnt4),  32'd0);
        check("rst_best",  32'(best4), 32'd0);
        check("rst_w5j5",  32'({w5s, j5s, w5f, j5f}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Anti-diagonal table: unique optimum 3,2,1,0
        mode4 = 0;
        pulse_start4();
        check("a_busy_rise", {31'd0, busy4}, 32'd1);
        check("a_first_w",   32'(w4), 32'd0);
        check("a_first_j",   32'(j4), 32'd0);
        @(posedge clk);
        #1;
        check("a_second_wj", 32'({w4, j4}), 32'h5);
        wait_valid(0, 1000, cyc);
        check("a_busy_fall", {31'd0, busy4}, 32'd0);
        check("a_min",  32'(min4),  32'd4);
        check("a_cnt",  32'(cnt4),  32'd1);
        check("a_best", 32'(best4), bexp(32'h1B));
        @(posedge clk);
        #1;
        check("a_valid_once", {31'd0, valid4}, 32'd0);
        check("a_min_hold",   32'(min4), 32'd4);

        // Flat table: every assignment ties
        mode4 = 1;
        pulse_start4();
        wait_valid(0, 1000, cyc);
        check("b_min",  32'(min4),  32'd20);
        check("b_cnt",  32'(cnt4),  32'd24);
        check("b_best", 32'(best4), bexp(32'hE4));

        // Asynchronous reset in the middle of EVAL
        mode4 = 0;
        pulse_start4();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_busy", {31'd0, busy4}, 32'd0);
        check("r_min",  32'(min4), 32'd0);
        check("r_cnt",  32'(cnt4), 32'd0);
        check("r_best", 32'(best4), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        any_activity = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            any_activity = any_activity | valid4 | busy4;
        end
        check("r_no_valid", {31'd0, any_activity}, 32'd0);
        pulse_start4();
        wait_valid(0, 1000, cyc);
        check("r_min_after", 32'(min4),  32'd4);
        check("r_cnt_after", 32'(cnt4),  32'd1);
        check("r_best_after", 32'(best4), bexp(32'h1B));

        // start held high: ignored while busy, restarts on the Valid cycle
        mode4  = 2;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        wait_valid(0, 1000, cyc);
        check("h_min",  32'(min4),  32'd12);
        check("h_cnt",  32'(cnt4),  32'd1);
        check("h_best", 32'(best4), bexp(32'hB1));
        mode4 = 1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        check("h_restart_busy",  {31'd0, busy4},  32'd1);
        check("h_restart_valid", {31'd0, valid4}, 32'd0);
        check("h_restart_wj",    32'({w4, j4}),   32'd0);
        wait_valid(0, 1000, cyc);
        check("h2_min",  32'(min4),  32'd20);
        check("h2_cnt",  32'(cnt4),  32'd24);
        check("h2_best", 32'(best4), bexp(32'hE4));

        // N=3 identity-optimal table with latency check (6+7+6+7+6 + 6 = 38)
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        wait_valid(1, 200, cyc);
        check("n3_latency", 32'(cyc),   32'd38);
        check("n3_min",     32'(min3),  32'd0);
        check("n3_cnt",     32'(cnt3),  32'd1);
        check("n3_best",    32'(best3), bexp(32'h24));

        // N=5, all zero costs: 120 ties, saturating at 63 with a 6-bit count
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        wait_valid(2, 5000, cyc);
        check("n5_valid_f", {31'd0, valid5f}, 32'd1);
        check("n5_min_s",   32'(min5s),  32'd0);
        check("n5_min_f",   32'(min5f),  32'd0);
        check("n5_cnt_sat", 32'(cnt5s),  32'd63);
        check("n5_cnt_full", 32'(cnt5f), 32'd120);
        check("n5_best_s",  32'(best5s), bexp(32'h4688));
        check("n5_best_f",  32'(best5f), bexp(32'h4688));
        check("n5_busy",    {30'd0, busy5s, busy5f}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
